// File: rtl/rx_packet_framer.sv
// rx_packet_framer: decodes the host byte stream into framebuffer writes.
// Row-load packets ('L', row, 128 payload bytes, XOR checksum) write one
// 128-byte row of the 64x32 RGB565 framebuffer. Fill packets ('F', hi, lo)
// paint all 4096 bytes with an alternating hi/lo pattern. Every output is
// driven straight from a flop.
module rx_packet_framer #(
  parameter int unsigned              TIMEOUT_WIDTH = 20,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 20'd727273,
  parameter logic [7:0]               ROW_BYTES     = 8'd128
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] ram_address,
  output logic [7:0]  ram_data_out,
  output logic        ram_write_enable,
  output logic        ram_clk_enable,
  output logic        busy,
  output logic        frame_done,
  output logic        error,
  output logic [7:0]  packets_ok
);

  localparam logic [7:0]               CMD_ROW      = 8'h4C;
  localparam logic [7:0]               CMD_FILL     = 8'h46;
  localparam logic [7:0]               ROW_COUNT    = 8'd32;
  localparam logic [6:0]               ROW_LAST     = 7'(ROW_BYTES - 8'd1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_TICKS - TIMEOUT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    PAYLOAD,
    CSUM,
    FILL_HI,
    FILL_LO,
    FILLING
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               row_q, row_d;
  logic [6:0]               byteIdx_q, byteIdx_d;
  logic [7:0]               csum_q, csum_d;
  logic [7:0]               fillHi_q, fillHi_d;
  logic [7:0]               fillLo_q, fillLo_d;
  logic [12:0]              fillCnt_q, fillCnt_d;
  logic [TIMEOUT_WIDTH-1:0] timeoutCnt_q, timeoutCnt_d;
  logic [11:0]              addr_q, addr_d;
  logic [7:0]               data_q, data_d;
  logic                     we_q, we_d;
  logic                     busy_q, busy_d;
  logic                     frameDone_q, frameDone_d;
  logic                     error_q, error_d;
  logic [7:0]               packetsOk_q, packetsOk_d;
  logic                     timedState;

  // Next-state and registered-output decode; the fill counter's bit 12 marks
  // the extra cycle after the last write where completion is reported.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    byteIdx_d    = byteIdx_q;
    csum_d       = csum_q;
    fillHi_d     = fillHi_q;
    fillLo_d     = fillLo_q;
    fillCnt_d    = fillCnt_q;
    timeoutCnt_d = '0;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    frameDone_d  = 1'b0;
    error_d      = 1'b0;
    packetsOk_d  = packetsOk_q;
    timedState   = (state_q == ROW) || (state_q == PAYLOAD) || (state_q == CSUM) ||
                   (state_q == FILL_HI) || (state_q == FILL_LO);

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_ROW) begin
            state_d = ROW;
          end else if (rx_data == CMD_FILL) begin
            state_d = FILL_HI;
          end
        end
      end
      ROW: begin
        if (rx_valid) begin
          if (rx_data < ROW_COUNT) begin
            row_d     = rx_data[4:0];
            csum_d    = rx_data;
            byteIdx_d = '0;
            state_d   = PAYLOAD;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          we_d   = 1'b1;
          addr_d = {row_q, byteIdx_q};
          data_d = rx_data;
          csum_d = csum_q ^ rx_data;
          if (byteIdx_q == ROW_LAST) begin
            state_d = CSUM;
          end else begin
            byteIdx_d = byteIdx_q + 7'd1;
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            frameDone_d = 1'b1;
            packetsOk_d = packetsOk_q + 8'd1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      FILL_HI: begin
        if (rx_valid) begin
          fillHi_d = rx_data;
          state_d  = FILL_LO;
        end
      end
      FILL_LO: begin
        if (rx_valid) begin
          fillLo_d  = rx_data;
          fillCnt_d = '0;
          state_d   = FILLING;
        end
      end
      FILLING: begin
        if (rx_valid) begin
          error_d = 1'b1;
        end
        if (fillCnt_q[12]) begin
          frameDone_d = 1'b1;
          packetsOk_d = packetsOk_q + 8'd1;
          state_d     = IDLE;
        end else begin
          we_d      = 1'b1;
          addr_d    = fillCnt_q[11:0];
          data_d    = fillCnt_q[0] ? fillLo_q : fillHi_q;
          fillCnt_d = fillCnt_q + 13'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timedState && !rx_valid) begin
      if (timeoutCnt_q == TIMEOUT_LAST) begin
        error_d = 1'b1;
        state_d = IDLE;
      end else begin
        timeoutCnt_d = timeoutCnt_q + TIMEOUT_WIDTH'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      byteIdx_q    <= '0;
      csum_q       <= '0;
      fillHi_q     <= '0;
      fillLo_q     <= '0;
      fillCnt_q    <= '0;
      timeoutCnt_q <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      frameDone_q  <= 1'b0;
      error_q      <= 1'b0;
      packetsOk_q  <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      byteIdx_q    <= byteIdx_d;
      csum_q       <= csum_d;
      fillHi_q     <= fillHi_d;
      fillLo_q     <= fillLo_d;
      fillCnt_q    <= fillCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      frameDone_q  <= frameDone_d;
      error_q      <= error_d;
      packetsOk_q  <= packetsOk_d;
    end
  end

  assign ram_address      = addr_q;
  assign ram_data_out     = data_q;
  assign ram_write_enable = we_q;
  assign ram_clk_enable   = we_q;
  assign busy             = busy_q;
  assign frame_done       = frameDone_q;
  assign error            = error_q;
  assign packets_ok       = packetsOk_q;

endmodule

// File: tb/tb_rx_packet_framer.sv
// tb_rx_packet_framer: drives row/fill packets with random content and random
// inter-byte gaps, and compares the framebuffer image and pulse counts
// against a byte-array model of the packet rules.
`timescale 1ns/1ps
module tb_rx_packet_framer;

  localparam logic [19:0] TICKS   = 20'd16;
  localparam int          GAP_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable;
  logic        ram_clk_enable;
  logic        busy;
  logic        frame_done;
  logic        error;
  logic [7:0]  packets_ok;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [7:0] expRam [4096];
  int         expErr = 0;
  int         expDone = 0;
  int         expPackets = 0;

  // Observed state, collected by the monitor
  logic [7:0] dutRam [4096];
  int cycle = 0;
  int writeCnt = 0;
  int errCnt = 0;
  int doneCnt = 0;
  int lastWriteCycle = 0;
  int doneCycle = 0;
  int runLen = 0;
  int lastRunLen = 0;
  int busyLowWrites = 0;
  int ceMismatch = 0;

  rx_packet_framer #(
    .TIMEOUT_WIDTH(20),
    .TIMEOUT_TICKS(TICKS),
    .ROW_BYTES(8'd128)
  ) dut (
    .clk_in(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .ram_address(ram_address),
    .ram_data_out(ram_data_out),
    .ram_write_enable(ram_write_enable),
    .ram_clk_enable(ram_clk_enable),
    .busy(busy),
    .frame_done(frame_done),
    .error(error),
    .packets_ok(packets_ok)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Capture writes and pulses away from the active edge
  always @(negedge clk) begin
    cycle++;
    if (ram_write_enable === 1'b1) begin
      dutRam[ram_address] = ram_data_out;
      writeCnt++;
      lastWriteCycle = cycle;
      runLen++;
      if (busy !== 1'b1) busyLowWrites++;
    end else begin
      if (runLen != 0) lastRunLen = runLen;
      runLen = 0;
    end
    if (error === 1'b1) errCnt++;
    if (frame_done === 1'b1) begin
      doneCnt++;
      doneCycle = cycle;
    end
    if (ram_clk_enable !== ram_write_enable) ceMismatch++;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed=stalled required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Waits 'gap' silent edges, then presents one byte for one cycle
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic int ramMismatches();
    int n = 0;
    for (int a = 0; a < 4096; a++) if (dutRam[a] !== expRam[a]) n++;
    return n;
  endfunction

  function automatic logic [7:0] rowChecksum(input int row, input logic [7:0] p [128]);
    logic [7:0] c = 8'(row);
    for (int i = 0; i < 128; i++) c ^= p[i];
    return c;
  endfunction

  task automatic rowPacket(input int row, input logic [7:0] p [128],
                           input logic [7:0] sentCsum, input int maxGap);
    int wBase = writeCnt;
    applyStimulus(8'h4C, $urandom_range(0, maxGap));
    applyStimulus(8'(row), $urandom_range(0, maxGap));
    for (int i = 0; i < 128; i++) begin
      applyStimulus(p[i], (i == 0) ? 0 : $urandom_range(0, maxGap));
      expRam[row * 128 + i] = p[i];
      if (i == 0) begin
        checkOutput("rowFirstWriteEn", 32'(ram_write_enable), 32'd1);
        checkOutput("rowFirstWriteAddr", 32'(ram_address), 32'(row * 128));
        checkOutput("rowFirstWriteData", 32'(ram_data_out), 32'(p[0]));
      end
    end
    applyStimulus(sentCsum, $urandom_range(0, maxGap));
    if (sentCsum == rowChecksum(row, p)) begin
      expDone++;
      expPackets = (expPackets + 1) % 256;
    end else begin
      expErr++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rowWrites", 32'(writeCnt - wBase), 32'd128);
    checkOutput("rowErrors", 32'(errCnt), 32'(expErr));
    checkOutput("rowDone", 32'(doneCnt), 32'(expDone));
    checkOutput("rowPacketsOk", 32'(packets_ok), 32'(expPackets));
    checkOutput("rowBusyIdle", 32'(busy), 32'd0);
    checkOutput("rowRamImage", 32'(ramMismatches()), 32'd0);
  endtask

  task automatic fillPacket(input logic [7:0] hi, input logic [7:0] lo, input int injectAt);
    int  wBase = writeCnt;
    int  dBase = doneCnt;
    int  n = 0;
    bit  injected = 1'b0;
    applyStimulus(8'h46, 1);
    applyStimulus(hi, 1);
    applyStimulus(lo, 1);
    while (doneCnt == dBase && n < 6000) begin
      @(posedge clk);
      n++;
      if (injectAt >= 0 && !injected && (writeCnt - wBase) >= injectAt) begin
        applyStimulus(8'h4C, 0);
        injected = 1'b1;
      end
    end
    checkOutput("fillCompleted", 32'(doneCnt - dBase), 32'd1);
    for (int a = 0; a < 4096; a++) expRam[a] = (a % 2 == 0) ? hi : lo;
    expDone++;
    expPackets = (expPackets + 1) % 256;
    if (injected) expErr++;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("fillWrites", 32'(writeCnt - wBase), 32'd4096);
    checkOutput("fillConsecutive", 32'(lastRunLen), 32'd4096);
    checkOutput("fillDoneAfterLast", 32'(doneCycle), 32'(lastWriteCycle + 1));
    checkOutput("fillErrors", 32'(errCnt), 32'(expErr));
    checkOutput("fillPacketsOk", 32'(packets_ok), 32'(expPackets));
    checkOutput("fillAddr0", 32'(dutRam[0]), 32'(hi));
    checkOutput("fillAddr1", 32'(dutRam[1]), 32'(lo));
    checkOutput("fillAddr4095", 32'(dutRam[4095]), 32'(lo));
    checkOutput("fillRamImage", 32'(ramMismatches()), 32'd0);
    checkOutput("fillBusyIdle", 32'(busy), 32'd0);
  endtask

  logic [7:0] pl [128];
  logic [7:0] g;
  logic [7:0] cs;
  int         wb;
  int         eb;
  int         row;

  initial begin
    for (int a = 0; a < 4096; a++) begin
      expRam[a] = 8'h00;
      dutRam[a] = 8'h00;
    end
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetAddr", 32'(ram_address), 32'd0);
    checkOutput("resetData", 32'(ram_data_out), 32'd0);
    checkOutput("resetWe", 32'(ram_write_enable), 32'd0);
    checkOutput("resetCe", 32'(ram_clk_enable), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(frame_done), 32'd0);
    checkOutput("resetError", 32'(error), 32'd0);
    checkOutput("resetPackets", 32'(packets_ok), 32'd0);
    reset = 1'b0;

    // Row 3 with an incrementing payload, correct then wrong checksum
    for (int i = 0; i < 128; i++) pl[i] = 8'(i);
    rowPacket(3, pl, 8'h03, 1);
    rowPacket(3, pl, 8'h04, 1);

    // Out-of-range row aborts without writing
    wb = writeCnt;
    eb = errCnt;
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h20, 1);
    repeat (3) @(posedge clk);
    #1;
    expErr++;
    checkOutput("badRowError", 32'(errCnt - eb), 32'd1);
    checkOutput("badRowWrites", 32'(writeCnt - wb), 32'd0);
    checkOutput("badRowBusy", 32'(busy), 32'd0);

    // Random packets with gaps up to one short of the timeout
    for (int k = 0; k < 4; k++) begin
      row = $urandom_range(0, 31);
      for (int i = 0; i < 128; i++) pl[i] = 8'($urandom);
      cs = rowChecksum(row, pl);
      if (k == 2) cs ^= 8'($urandom_range(1, 255));
      rowPacket(row, pl, cs, GAP_MAX);
    end

    // Non-command bytes in idle are ignored
    wb = writeCnt;
    for (int k = 0; k < 6; k++) begin
      do g = 8'($urandom); while (g == 8'h4C || g == 8'h46);
      applyStimulus(g, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idleJunkWrites", 32'(writeCnt - wb), 32'd0);
    checkOutput("idleJunkBusy", 32'(busy), 32'd0);
    checkOutput("idleJunkErrors", 32'(errCnt), 32'(expErr));

    // Fills: directed pattern, then random pattern with an overrun byte
    fillPacket(8'hF8, 8'h00, -1);
    fillPacket(8'($urandom), 8'($urandom), 100);

    // Silence inside a row aborts after the timeout
    wb = writeCnt;
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      g = 8'($urandom);
      applyStimulus(g, $urandom_range(0, GAP_MAX));
      expRam[i] = g;
    end
    repeat (int'(TICKS) + 4) @(posedge clk);
    #1;
    expErr++;
    checkOutput("timeoutErrors", 32'(errCnt), 32'(expErr));
    checkOutput("timeoutWrites", 32'(writeCnt - wb), 32'd5);
    checkOutput("timeoutBusy", 32'(busy), 32'd0);
    checkOutput("timeoutRamImage", 32'(ramMismatches()), 32'd0);
    wb = writeCnt;
    applyStimulus(8'h58, 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("afterTimeoutWrites", 32'(writeCnt - wb), 32'd0);
    checkOutput("afterTimeoutErrors", 32'(errCnt), 32'(expErr));
    checkOutput("afterTimeoutDone", 32'(doneCnt), 32'(expDone));
    checkOutput("afterTimeoutBusy", 32'(busy), 32'd0);

    // Reset in the middle of a row stops writing and clears the count
    wb = writeCnt;
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h01, 1);
    for (int i = 0; i < 3; i++) begin
      g = 8'($urandom);
      applyStimulus(g, 1);
      expRam[128 + i] = g;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expPackets = 0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midResetWrites", 32'(writeCnt - wb), 32'd3);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetPackets", 32'(packets_ok), 32'(expPackets));
    checkOutput("midResetRamImage", 32'(ramMismatches()), 32'd0);

    // A packet after reset counts from zero
    row = $urandom_range(0, 31);
    for (int i = 0; i < 128; i++) pl[i] = 8'($urandom);
    rowPacket(row, pl, rowChecksum(row, pl), 3);

    checkOutput("busyDuringWrites", 32'(busyLowWrites), 32'd0);
    checkOutput("clkEnableTracksWe", 32'(ceMismatch), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_packet_framer.md
Name: rx_packet_framer

Overview:
- Byte-level packet decoder between the image-data UART receiver and framebuffer port A (12-bit byte address, 8-bit data, 64x32 RGB565 = 4096 bytes).
- Parses row-load and fill packets from the host stream and issues one framebuffer write per clock.
- Reports packet completion, errors and a processed-packet count.

Parameters:
- TIMEOUT_TICKS, 20'd727273, clocks of inter-byte silence tolerated inside a packet before abort.
- TIMEOUT_WIDTH, 5'd20, width of the timeout counter.
- ROW_BYTES, 8'd128, payload bytes per row packet (64 pixels x 2 bytes).

Ports:
- clk_in  input  1  system clock (clk_root domain).
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received UART byte, valid only while rx_valid is high.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte.
- ram_address  output  12  framebuffer port A byte address.
- ram_data_out  output  8  framebuffer port A write data.
- ram_write_enable  output  1  write strobe, one byte per cycle.
- ram_clk_enable  output  1  port A clock enable, equal to ram_write_enable.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse when a packet completes successfully.
- error  output  1  one-cycle pulse on checksum mismatch, timeout, bad row or overrun.
- packets_ok  output  8  count of successful packets, wraps 255 to 0.

Behaviour:
- Reset: state IDLE. ram_address=0, ram_data_out=0, ram_write_enable=0, ram_clk_enable=0, busy=0, frame_done=0, error=0, packets_ok=0. Checksum and timeout counters cleared.
- Reset mid-operation aborts the packet at the next edge. No further writes occur; bytes already written stay in RAM.
- All outputs are registered.

Packet formats:
- Row load: 'L' (0x4C), row, 128 payload bytes, csum.
  - csum = XOR of the row byte and all payload bytes.
- Fill: 'F' (0x46), hi, lo.

State machine:
- IDLE:
  - 0x4C moves to ROW.
  - 0x46 moves to FILL_HI.
  - Any other byte is ignored silently.
- ROW:
  - Byte < 32: latch the row, csum=byte, byte_idx=0, move to PAYLOAD.
  - Byte >= 32: pulse error, move to IDLE.
- PAYLOAD:
  - Each byte writes in the cycle after rx_valid: ram_address={row[4:0], byte_idx[6:0]}, ram_data_out=byte, ram_write_enable=1 for exactly 1 cycle.
  - csum ^= byte.
  - After byte_idx reaches ROW_BYTES-1, move to CSUM.
- CSUM:
  - Byte == csum: pulse frame_done, packets_ok+1.
  - Otherwise: pulse error.
  - Either way, move to IDLE.
  - Row data is already written and is not rolled back.
- FILL_HI: latch hi, move to FILL_LO.
- FILL_LO: latch lo, move to FILLING.
- FILLING:
  - Writes every cycle, addresses 0..4095. Even addresses take hi, odd addresses take lo.
  - Takes exactly 4096 consecutive write cycles, starting the cycle after entry.
  - On the cycle after the address-4095 write: frame_done pulse, packets_ok+1, move to IDLE.

Timeout:
- Counter clears on every rx_valid and counts while in ROW, PAYLOAD, CSUM, FILL_HI or FILL_LO.
- Reaching TIMEOUT_TICKS-1: pulse error, move to IDLE.
- No timeout applies in IDLE or FILLING.

Overrun:
- rx_valid during FILLING: byte dropped, error pulses for 1 cycle, the fill continues.

Simultaneous events:
- If frame_done and an overrun error coincide, both pulse in the same cycle.
- If rx_valid arrives in the same cycle as a timeout expiry, the byte wins: the counter clears and no error is raised.

Test Plan:
- Reset, then 'L', 0x03, payload bytes 0x00..0x7F, csum 0x03 -> 128 writes at addresses 0x180..0x1FF with data equal to the low 7 address bits; frame_done pulses once; packets_ok=1; error never asserts.
- Same packet with csum 0x04 -> all 128 writes occur, error pulses once, frame_done stays low, packets_ok unchanged.
- 'L', 0x20 -> error pulse, no writes, state IDLE; a following valid packet succeeds.
- 'F', 0xF8, 0x00 -> exactly 4096 consecutive write cycles; address 0 gets 0xF8, address 1 gets 0x00, address 4095 gets 0x00; busy stays high throughout; frame_done on the cycle after the last write.
- During a fill, inject rx_valid at write 100 -> error pulses for 1 cycle, the fill still completes with 4096 writes, packets_ok increments.
- 'L', 0x00, then 5 payload bytes, then silence of TIMEOUT_TICKS (use 16 in simulation) -> error pulse, busy drops, only 5 writes occur; a subsequent 'X' byte causes nothing.
